// File: rtl/div_sqrt_pkg.sv
// Shared types for the div/sqrt issuer: default widths, response record, exception-flag bit positions.
// The resp_t record matches the default fp32 configuration (tag, op type, recoded result, flags).
package div_sqrt_pkg;

  localparam int EXP_W  = 8;
  localparam int SIG_W  = 24;
  localparam int TAG_W  = 4;
  localparam int REC_W  = EXP_W + SIG_W + 1;
  localparam int FLAG_W = 5;

  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_INFINITE  = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic              sqrt_op;
    logic [REC_W-1:0]  out;
    logic [FLAG_W-1:0] flags;
  } resp_t;

endpackage

// File: rtl/div_sqrt_resp_fifo.sv
// Synchronous FIFO holding completed responses; head is read combinationally, so a push shows up
// on the output one cycle later. Push and pop may coincide at any occupancy, including full.
module div_sqrt_resp_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1),
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/div_sqrt_rec_fn_issuer.sv
// Issues tagged div/sqrt requests to divSqrtRecFN_medium only against reserved response-FIFO credit;
// results reach resp_* one cycle after unit_outValid. Optional DIV_SQRT_ISSUER_WATCHDOG_EN adds a hang detector.
module div_sqrt_rec_fn_issuer
  import div_sqrt_pkg::*;
#(
  parameter int expWidth = EXP_W,
  parameter int sigWidth = SIG_W,
  parameter int tagWidth = TAG_W,
  parameter int depth    = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_sqrtOp,
  input  logic [expWidth+sigWidth:0] req_a,
  input  logic [expWidth+sigWidth:0] req_b,
  input  logic [2:0]                 req_roundingMode,
  input  logic [tagWidth-1:0]        req_tag,
  input  logic                       unit_inReady,
  output logic                       unit_inValid,
  output logic                       unit_sqrtOp,
  output logic [expWidth+sigWidth:0] unit_a,
  output logic [expWidth+sigWidth:0] unit_b,
  output logic [2:0]                 unit_roundingMode,
  input  logic                       unit_outValid,
  input  logic                       unit_sqrtOpOut,
  input  logic [expWidth+sigWidth:0] unit_out,
  input  logic [4:0]                 unit_exceptionFlags,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [tagWidth-1:0]        resp_tag,
  output logic                       resp_sqrtOp,
  output logic [expWidth+sigWidth:0] resp_out,
  output logic [4:0]                 resp_flags,
  output logic                       proto_err,
  output logic                       watchdog_err
);

  localparam int REC = expWidth + sigWidth + 1;
  localparam int CW  = $clog2(depth + 1);

  typedef struct packed {
    logic [tagWidth-1:0] tag;
    logic                sqrt_op;
    logic [REC-1:0]      out;
    logic [FLAG_W-1:0]   flags;
  } rsp_t;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state;
  logic [tagWidth-1:0] inflight_tag;
  logic                inflight;
  logic                credit_ok;
  logic                fire;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [CW-1:0]       count;
  rsp_t                push_dat;
  rsp_t                pop_dat;

  assign inflight = (state == BUSY);
  // Credit counts the op still inside the unit, since the unit cannot be stalled once it finishes.
  assign credit_ok = (int'(count) + int'(inflight)) < depth;

  assign req_ready         = unit_inReady & credit_ok;
  assign unit_inValid      = req_valid & credit_ok;
  assign fire              = req_valid & req_ready;
  assign unit_sqrtOp       = req_sqrtOp;
  assign unit_a            = req_a;
  assign unit_b            = req_b;
  assign unit_roundingMode = req_roundingMode;

  assign push     = unit_outValid & inflight;
  assign push_dat = '{tag: inflight_tag, sqrt_op: unit_sqrtOpOut, out: unit_out, flags: unit_exceptionFlags};
  assign pop      = resp_valid & resp_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      inflight_tag <= '0;
      proto_err    <= 1'b0;
    end else begin
      // A completion and a new issue in the same cycle leave the FSM busy with the new tag.
      if (fire) begin
        state        <= BUSY;
        inflight_tag <= req_tag;
      end else if (unit_outValid) begin
        state <= IDLE;
      end
      if (unit_outValid && !inflight) proto_err <= 1'b1;
    end
  end

  div_sqrt_resp_fifo #(
    .WIDTH($bits(rsp_t)),
    .DEPTH(depth),
    .CW   (CW)
  ) u_resp_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .push_dat(push_dat),
    .pop     (pop),
    .pop_dat (pop_dat),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign resp_valid  = !empty;
  assign resp_tag    = pop_dat.tag;
  assign resp_sqrtOp = pop_dat.sqrt_op;
  assign resp_out    = pop_dat.out;
  assign resp_flags  = pop_dat.flags;

  no_overflow: assert property (@(posedge clock) disable iff (reset) !(push && full && !pop));

`ifdef DIV_SQRT_ISSUER_WATCHDOG_EN
  localparam int WD_LIMIT = sigWidth + 4;
  localparam int WW       = $clog2(WD_LIMIT + 1);

  logic [WW-1:0] wd_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt       <= '0;
      watchdog_err <= 1'b0;
    end else begin
      if (fire)
        wd_cnt <= '0;
      else if (inflight && wd_cnt != WW'(WD_LIMIT))
        wd_cnt <= wd_cnt + 1'b1;
      if (inflight && !unit_outValid && wd_cnt == WW'(WD_LIMIT)) watchdog_err <= 1'b1;
    end
  end
`else
  assign watchdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_div_sqrt_rec_fn_issuer.sv
// Bench for div_sqrt_rec_fn_issuer: the bench plays the divSqrtRecFN unit and tracks
// outstanding ops, the expected response order and credit at transaction level.
module tb_div_sqrt_rec_fn_issuer;
  import div_sqrt_pkg::*;

  localparam int DEPTH = 2;

  localparam logic [32:0] R0   = {1'b0, 9'h000, 23'h000000};
  localparam logic [32:0] R1   = {1'b0, 9'h100, 23'h000000};
  localparam logic [32:0] R2   = {1'b0, 9'h101, 23'h000000};
  localparam logic [32:0] R3   = {1'b0, 9'h101, 23'h400000};
  localparam logic [32:0] R6   = {1'b0, 9'h102, 23'h400000};
  localparam logic [32:0] R9   = {1'b0, 9'h103, 23'h100000};
  localparam logic [32:0] RM4  = {1'b1, 9'h102, 23'h000000};
  localparam logic [32:0] RINF = {1'b0, 9'h180, 23'h000000};
  localparam logic [32:0] RNAN = {1'b0, 9'h1C0, 23'h400000};

  logic        clock;
  logic        reset;
  logic        req_valid, req_ready, req_sqrtOp;
  logic [32:0] req_a, req_b;
  logic [2:0]  req_roundingMode;
  logic [3:0]  req_tag;
  logic        unit_inReady, unit_inValid, unit_sqrtOp;
  logic [32:0] unit_a, unit_b;
  logic [2:0]  unit_roundingMode;
  logic        unit_outValid, unit_sqrtOpOut;
  logic [32:0] unit_out;
  logic [4:0]  unit_exceptionFlags;
  logic        resp_valid, resp_ready, resp_sqrtOp;
  logic [3:0]  resp_tag;
  logic [32:0] resp_out;
  logic [4:0]  resp_flags;
  logic        proto_err, watchdog_err;

  div_sqrt_rec_fn_issuer #(.expWidth(8), .sigWidth(24), .tagWidth(4), .depth(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_sqrtOp(req_sqrtOp),
    .req_a(req_a), .req_b(req_b), .req_roundingMode(req_roundingMode), .req_tag(req_tag),
    .unit_inReady(unit_inReady), .unit_inValid(unit_inValid), .unit_sqrtOp(unit_sqrtOp),
    .unit_a(unit_a), .unit_b(unit_b), .unit_roundingMode(unit_roundingMode),
    .unit_outValid(unit_outValid), .unit_sqrtOpOut(unit_sqrtOpOut), .unit_out(unit_out),
    .unit_exceptionFlags(unit_exceptionFlags),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_tag(resp_tag),
    .resp_sqrtOp(resp_sqrtOp), .resp_out(resp_out), .resp_flags(resp_flags),
    .proto_err(proto_err), .watchdog_err(watchdog_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        sqrt;
    logic [32:0] a;
    logic [32:0] b;
    logic [2:0]  rm;
    logic [3:0]  tag;
    int          lat;
    logic [32:0] out;
    logic [4:0]  flags;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Unit model and scoreboard state
  logic        u_busy;
  int          u_cnt;
  logic [3:0]  u_tag;
  logic        u_sqrt;
  logic [32:0] u_out;
  logic [4:0]  u_flags;
  resp_t       expq[$];
  resp_t       popq[$];
  logic        exp_proto;
  bit          force_ov, last_fire, fire_in_completion;
  int          issued;

  logic        drv_req_valid, drv_sqrt, drv_resp_ready;
  logic [32:0] drv_a, drv_b;
  logic [2:0]  drv_rm;
  logic [3:0]  drv_tag;
  int          drv_lat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void unit_calc(input logic s, input logic [32:0] a, input logic [32:0] b,
                                    output logic [32:0] o, output logic [4:0] f);
    o = a ^ {b[31:0], b[32]};
    f = a[4:0] ^ b[4:0];
    if (!s && a == R6 && b == R3) begin o = R2; f = 5'b0; end
    else if (s && a == RM4)       begin o = RNAN; f = 5'b10000; end
    else if (!s && a == R1 && b == R0) begin o = RINF; f = 5'b01000; end
    else if (s && a == R9)        begin o = R3; f = 5'b0; end
  endfunction

  task automatic cycle();
    bit    comp, fire, pop;
    int    outstanding;
    resp_t r;
    @(negedge clock);
    comp                = u_busy && (u_cnt == 0);
    unit_outValid       = comp || force_ov;
    unit_inReady        = !u_busy || comp;
    unit_sqrtOpOut      = u_sqrt;
    unit_out            = u_out;
    unit_exceptionFlags = u_flags;
    req_valid           = drv_req_valid;
    req_sqrtOp          = drv_sqrt;
    req_a               = drv_a;
    req_b               = drv_b;
    req_roundingMode    = drv_rm;
    req_tag             = drv_tag;
    resp_ready          = drv_resp_ready;
    #1;
    outstanding = int'(u_busy) + expq.size();
    chk("req_ready", 64'(req_ready), 64'(unit_inReady && (outstanding < DEPTH)));
    chk("unit_inValid", 64'(unit_inValid), 64'(req_valid && (outstanding < DEPTH)));
    chk("resp_valid", 64'(resp_valid), 64'(expq.size() != 0));
    chk("proto_err", 64'(proto_err), 64'(exp_proto));
    chk("watchdog_err", 64'(watchdog_err), 64'(0));
    if (drv_req_valid) begin
      chk("unit_a", 64'(unit_a), 64'(drv_a));
      chk("unit_b_op_rm", 64'({unit_sqrtOp, unit_roundingMode, unit_b}), 64'({drv_sqrt, drv_rm, drv_b}));
    end
    r = '{tag: resp_tag, sqrt_op: resp_sqrtOp, out: resp_out, flags: resp_flags};
    if (resp_valid && expq.size() != 0) chk("resp_data", 64'(r), 64'(expq[0]));
    fire = req_valid && req_ready;
    pop  = resp_valid && resp_ready;
    if (unit_outValid && !u_busy) exp_proto = 1'b1;
    if (pop && expq.size() != 0) begin
      popq.push_back(r);
      void'(expq.pop_front());
    end
    if (comp) expq.push_back('{tag: u_tag, sqrt_op: u_sqrt, out: u_out, flags: u_flags});
    fire_in_completion = fire && comp;
    if (fire) begin
      u_busy = 1'b1;
      u_cnt  = drv_lat - 1;
      u_tag  = drv_tag;
      u_sqrt = drv_sqrt;
      unit_calc(drv_sqrt, drv_a, drv_b, u_out, u_flags);
      issued++;
    end else if (comp) begin
      u_busy = 1'b0;
    end else if (u_busy) begin
      u_cnt--;
    end
    last_fire = fire;
  endtask

  task automatic wait_fire(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (last_fire) begin ok = 1; break; end
    end
  endtask

  task automatic wait_pops(input int n, input int budget, output bit ok);
    for (int i = 0; i < budget && popq.size() < n; i++) cycle();
    ok = (popq.size() >= n);
  endtask

  task automatic set_req(input logic s, input logic [32:0] a, input logic [32:0] b,
                         input logic [2:0] rm, input logic [3:0] tag, input int lat);
    drv_req_valid = 1'b1; drv_sqrt = s; drv_a = a; drv_b = b; drv_rm = rm; drv_tag = tag; drv_lat = lat;
  endtask

  task automatic drain(input string name);
    drv_req_valid  = 1'b0;
    drv_resp_ready = 1'b1;
    for (int i = 0; i < 100 && (u_busy || expq.size() != 0); i++) cycle();
    chk(name, 64'(u_busy || expq.size() != 0), 64'(0));
  endtask

  task automatic apply_reset(input int hold);
    @(negedge clock);
    reset         = 1'b1;
    drv_req_valid = 1'b0;
    req_valid     = 1'b0;
    force_ov      = 1'b0;
    unit_outValid = 1'b0;
    unit_inReady  = 1'b1;
    #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_unit_inValid", 64'(unit_inValid), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_proto_err", 64'(proto_err), 64'(0));
    chk("rst_watchdog_err", 64'(watchdog_err), 64'(0));
    repeat (hold) @(negedge clock);
    #1;
    chk("rst_hold_resp_valid", 64'(resp_valid), 64'(0));
    u_busy    = 1'b0;
    u_cnt     = 0;
    exp_proto = 1'b0;
    expq.delete();
    reset     = 1'b0;
  endtask

  task automatic run_vec(input string name, input vec_t v);
    bit ok;
    int n0;
    n0 = popq.size();
    drv_resp_ready = 1'b1;
    set_req(v.sqrt, v.a, v.b, v.rm, v.tag, v.lat);
    wait_fire(50, ok);
    chk({name, "_fire"}, 64'(ok), 64'(1));
    drv_req_valid = 1'b0;
    wait_pops(n0 + 1, 80, ok);
    chk({name, "_resp_seen"}, 64'(ok), 64'(1));
    if (ok) begin
      chk({name, "_tag"}, 64'(popq[n0].tag), 64'(v.tag));
      chk({name, "_sqrtOp"}, 64'(popq[n0].sqrt_op), 64'(v.sqrt));
      chk({name, "_out"}, 64'(popq[n0].out), 64'(v.out));
      chk({name, "_flags"}, 64'(popq[n0].flags), 64'(v.flags));
    end
  endtask

  vec_t vecs[5];

  initial begin
    bit ok;
    int p0, n0;
    vec_t v;

    reset = 1'b1;
    req_valid = 1'b0; req_sqrtOp = 1'b0; req_a = '0; req_b = '0; req_roundingMode = '0; req_tag = '0;
    unit_inReady = 1'b1; unit_outValid = 1'b0; unit_sqrtOpOut = 1'b0; unit_out = '0;
    unit_exceptionFlags = '0; resp_ready = 1'b0;
    drv_req_valid = 1'b0; drv_sqrt = 1'b0; drv_a = '0; drv_b = '0; drv_rm = '0; drv_tag = '0;
    drv_lat = 1; drv_resp_ready = 1'b0;
    u_busy = 1'b0; u_cnt = 0; u_tag = '0; u_sqrt = 1'b0; u_out = '0; u_flags = '0;
    exp_proto = 1'b0; force_ov = 1'b0; last_fire = 0; fire_in_completion = 0; issued = 0;

    vecs[0] = '{sqrt: 1'b0, a: R6,  b: R3, rm: 3'd0, tag: 4'd5,  lat: 10, out: R2,   flags: 5'b00000};
    vecs[1] = '{sqrt: 1'b1, a: RM4, b: R0, rm: 3'd0, tag: 4'd1,  lat: 1,  out: RNAN, flags: 5'(1 << FLAG_INVALID)};
    vecs[2] = '{sqrt: 1'b0, a: R1,  b: R0, rm: 3'd2, tag: 4'd15, lat: 1,  out: RINF, flags: 5'(1 << FLAG_INFINITE)};
    vecs[3] = '{sqrt: 1'b1, a: R9,  b: R0, rm: 3'd4, tag: 4'd0,  lat: 12, out: R3,   flags: 5'b00000};
    vecs[4] = '{sqrt: 1'b0, a: R6,  b: R3, rm: 3'd1, tag: 4'd10, lat: 2,  out: R2,   flags: 5'b00000};

    apply_reset(2);

    // Single-op vectors: results, tags and special-case one-cycle completions.
    for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Issue in the completion cycle of a one-cycle special case.
    drain("t3_idle");
    p0 = popq.size();
    drv_resp_ready = 1'b1;
    set_req(1'b0, R1, R0, 3'd0, 4'd2, 1);
    wait_fire(20, ok);
    chk("t3_first_fire", 64'(ok), 64'(1));
    set_req(1'b1, R9, R0, 3'd0, 4'd3, 10);
    cycle();
    chk("t3_b2b_issue", 64'(fire_in_completion), 64'(1));
    drv_req_valid = 1'b0;
    wait_pops(p0 + 2, 80, ok);
    chk("t3_done", 64'(ok), 64'(1));
    if (ok) begin
      chk("t3_tag0", 64'(popq[p0].tag), 64'(2));
      chk("t3_out0", 64'(popq[p0].out), 64'(RINF));
      chk("t3_flags0", 64'(popq[p0].flags), 64'(5'b01000));
      chk("t3_tag1", 64'(popq[p0 + 1].tag), 64'(3));
      chk("t3_out1", 64'(popq[p0 + 1].out), 64'(R3));
      chk("t3_flags1", 64'(popq[p0 + 1].flags), 64'(5'b00000));
    end

    // Credit exhaustion: two results parked, third request held until a pop.
    drain("t4_idle");
    drv_resp_ready = 1'b0;
    n0 = issued;
    p0 = popq.size();
    for (int k = 0; k < 3; k++) begin
      set_req(1'b0, R6, R3, 3'd0, 4'(8 + k), 3);
      wait_fire(30, ok);
      if (k < 2) chk("t4_issue", 64'(ok), 64'(1));
      else       chk("t4_third_held", 64'(ok), 64'(0));
    end
    chk("t4_issued_two", 64'(issued - n0), 64'(2));
    chk("t4_req_ready_low", 64'(req_ready), 64'(0));
    drv_resp_ready = 1'b1;
    wait_fire(10, ok);
    chk("t4_third_fire", 64'(ok), 64'(1));
    drv_req_valid = 1'b0;
    wait_pops(p0 + 3, 60, ok);
    chk("t4_done", 64'(ok), 64'(1));
    if (ok) for (int j = 0; j < 3; j++) chk("t4_order", 64'(popq[p0 + j].tag), 64'(8 + j));

    // Spurious completion strobe while idle.
    drain("t5_idle");
    p0 = popq.size();
    force_ov = 1'b1;
    cycle();
    force_ov = 1'b0;
    cycle();
    chk("t5_proto_err", 64'(proto_err), 64'(1));
    chk("t5_no_resp", 64'(resp_valid), 64'(0));
    cycle();
    chk("t5_no_pop", 64'(popq.size() - p0), 64'(0));

    // Reset in the middle of a long divide, then a clean op.
    drv_resp_ready = 1'b1;
    set_req(1'b0, R6, R3, 3'd0, 4'd4, 15);
    wait_fire(20, ok);
    chk("t6_fire", 64'(ok), 64'(1));
    drv_req_valid = 1'b0;
    repeat (4) cycle();
    apply_reset(1);
    v = '{sqrt: 1'b0, a: R6, b: R3, rm: 3'd0, tag: 4'd7, lat: 10, out: R2, flags: 5'b00000};
    run_vec("t6_after", v);

    // Randomized traffic with random backpressure and unit latencies.
    for (int c = 0; c < 1500; c++) begin
      if (!drv_req_valid && $urandom_range(1, 0) == 1)
        set_req(1'($urandom), {1'($urandom), 32'($urandom)}, {1'($urandom), 32'($urandom)},
                3'($urandom), 4'($urandom),
                ($urandom_range(3, 0) == 0) ? 1 : int'($urandom_range(12, 2)));
      drv_resp_ready = ($urandom_range(3, 0) != 0);
      cycle();
      if (last_fire) drv_req_valid = 1'b0;
    end
    drain("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
